// File: rtl/snake_step_sequencer.sv
// Snake game-tick sequencer: counts frame ticks, latches direction, and walks
// the segment RAM once per move period (shift body, write head, grow, collide).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_INIT  | write the initial straight body, one segment per cycle
// ST_WAIT  | count frame-tick rising edges until the move period ends
// ST_CALC  | compute the new head, check the walls, pick the shift top
// ST_SHIFT_A | present read address i-1
// ST_SHIFT_B | write segment i with the data read from i-1
// ST_HEAD  | write the new head, or stop on a self collision
// ST_OVER  | collision seen; frozen until reset
module snake_step_sequencer #(
  parameter int MAX_LEN       = 100,
  parameter int COORD_W       = 16,
  parameter int PERIOD_FRAMES = 8,
  parameter int STEP          = 10,
  parameter int X_MIN         = 50,
  parameter int X_MAX         = 449,
  parameter int Y_MIN         = 50,
  parameter int Y_MAX         = 441,
  parameter int INIT_X        = 200,
  parameter int INIT_Y        = 200,
  parameter int INIT_LEN      = 3,
  localparam int ADDR_W       = $clog2(MAX_LEN)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_frame_tick,
  input  logic                   i_btn_u,
  input  logic                   i_btn_r,
  input  logic                   i_btn_d,
  input  logic                   i_btn_l,
  input  logic                   i_grow,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic                   o_mem_wen,
  output logic [2*COORD_W-1:0]   o_mem_wdata,
  input  logic [2*COORD_W-1:0]   i_mem_rdata,
  output logic [COORD_W-1:0]     o_head_x,
  output logic [COORD_W-1:0]     o_head_y,
  output logic [ADDR_W:0]        o_length,
  output logic                   o_busy,
  output logic                   o_step_done,
  output logic                   o_game_over
);

  localparam int CNT_W = (PERIOD_FRAMES > 1) ? $clog2(PERIOD_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PERIOD_FRAMES - 1);
  localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STEP);
  localparam logic [COORD_W:0]   STEP_W     = (COORD_W + 1)'(STEP);
  localparam logic [COORD_W+1:0] STEP_M1    = (COORD_W + 2)'(STEP - 1);
  localparam logic [COORD_W:0]   XMIN_V     = (COORD_W + 1)'(X_MIN);
  localparam logic [COORD_W:0]   YMIN_V     = (COORD_W + 1)'(Y_MIN);
  localparam logic [COORD_W+1:0] XMAX_V     = (COORD_W + 2)'(X_MAX);
  localparam logic [COORD_W+1:0] YMAX_V     = (COORD_W + 2)'(Y_MAX);
  localparam logic [COORD_W-1:0] INIT_X_C   = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] INIT_Y_C   = COORD_W'(INIT_Y);
  localparam logic [ADDR_W:0]    INIT_LEN_V = (ADDR_W + 1)'(INIT_LEN);
  localparam logic [ADDR_W:0]    MAX_LEN_V  = (ADDR_W + 1)'(MAX_LEN);
  localparam logic [ADDR_W-1:0]  A_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  A_TWO      = ADDR_W'(2);

  typedef enum logic [2:0] {
    ST_INIT, ST_WAIT, ST_CALC, ST_SHIFT_A, ST_SHIFT_B, ST_HEAD, ST_OVER
  } state_t;

  typedef enum logic [1:0] {DIR_U = 2'd0, DIR_R = 2'd1, DIR_D = 2'd2, DIR_L = 2'd3} dir_t;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  state_t                r_state;
  dir_t                  r_dir, r_last_dir, r_step_dir;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic                  r_mem_wen;
  logic [2*COORD_W-1:0]  r_mem_wdata;
  logic [COORD_W-1:0]    r_head_x, r_head_y, r_nh_x, r_nh_y, r_init_x;
  logic [ADDR_W:0]       r_length, r_top, r_init_idx;
  logic [ADDR_W-1:0]     r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy, r_step_done, r_game_over;
  logic                  r_grow_pend, r_tick_d, r_self_hit;

  logic                  w_tick_rise, w_req_vld, w_wall, w_hit;
  dir_t                  w_req_dir;
  logic [COORD_W:0]      w_nh_x, w_nh_y;
  logic [COORD_W+1:0]    w_far_x, w_far_y;
  logic [ADDR_W:0]       w_top;

  assign w_tick_rise = i_frame_tick & ~r_tick_d;
  assign w_hit       = (i_mem_rdata == {r_nh_x, r_nh_y});

  // Button request with fixed priority U > R > D > L
  always_comb begin
    w_req_vld = 1'b1;
    w_req_dir = DIR_U;
    if (i_btn_u)      w_req_dir = DIR_U;
    else if (i_btn_r) w_req_dir = DIR_R;
    else if (i_btn_d) w_req_dir = DIR_D;
    else if (i_btn_l) w_req_dir = DIR_L;
    else              w_req_vld = 1'b0;
  end

  // Next head one bit wider than a coordinate so an underflow reads as huge
  always_comb begin
    w_nh_x = {1'b0, r_head_x};
    w_nh_y = {1'b0, r_head_y};
    case (r_dir)
      DIR_U:   w_nh_y = {1'b0, r_head_y} - STEP_W;
      DIR_R:   w_nh_x = {1'b0, r_head_x} + STEP_W;
      DIR_D:   w_nh_y = {1'b0, r_head_y} + STEP_W;
      default: w_nh_x = {1'b0, r_head_x} - STEP_W;
    endcase
    w_far_x = {1'b0, w_nh_x} + STEP_M1;
    w_far_y = {1'b0, w_nh_y} + STEP_M1;
    w_wall  = (w_nh_x < XMIN_V) || (w_far_x > XMAX_V) ||
              (w_nh_y < YMIN_V) || (w_far_y > YMAX_V);
    w_top   = (r_grow_pend && (r_length < MAX_LEN_V)) ? r_length : (r_length - 1'b1);
  end

  // Sequencer FSM with registered RAM and status outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_INIT;
      r_dir       <= DIR_R;
      r_last_dir  <= DIR_R;
      r_step_dir  <= DIR_R;
      r_mem_addr  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_head_x    <= INIT_X_C;
      r_head_y    <= INIT_Y_C;
      r_nh_x      <= '0;
      r_nh_y      <= '0;
      r_init_x    <= INIT_X_C;
      r_length    <= INIT_LEN_V;
      r_top       <= '0;
      r_init_idx  <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_step_done <= 1'b0;
      r_game_over <= 1'b0;
      r_grow_pend <= 1'b0;
      r_tick_d    <= 1'b0;
      r_self_hit  <= 1'b0;
    end else begin
      r_tick_d    <= i_frame_tick;
      r_step_done <= 1'b0;
      if (r_state != ST_INIT && r_state != ST_OVER && w_req_vld &&
          w_req_dir != opposite(r_last_dir))
        r_dir <= w_req_dir;
      case (r_state)
        ST_INIT: begin
          if (r_init_idx < INIT_LEN_V) begin
            r_mem_wen   <= 1'b1;
            r_mem_addr  <= r_init_idx[ADDR_W-1:0];
            r_mem_wdata <= {r_init_x, INIT_Y_C};
            r_init_x    <= r_init_x - STEP_C;
            r_init_idx  <= r_init_idx + 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_mem_wen  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_tick_rise) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_grow_pend <= 1'b0;
          r_nh_x      <= w_nh_x[COORD_W-1:0];
          r_nh_y      <= w_nh_y[COORD_W-1:0];
          r_step_dir  <= r_dir;
          r_self_hit  <= 1'b0;
          if (w_wall) begin
            r_game_over <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_OVER;
          end else begin
            r_top <= w_top;
            if (w_top == '0) begin
              r_mem_addr  <= '0;
              r_mem_wen   <= 1'b1;
              r_mem_wdata <= {w_nh_x[COORD_W-1:0], w_nh_y[COORD_W-1:0]};
              r_state     <= ST_HEAD;
            end else begin
              r_idx      <= w_top[ADDR_W-1:0];
              r_mem_addr <= w_top[ADDR_W-1:0] - A_ONE;
              r_state    <= ST_SHIFT_A;
            end
          end
        end
        ST_SHIFT_A: begin
          r_mem_wen  <= 1'b1;
          r_mem_addr <= r_idx;
          r_state    <= ST_SHIFT_B;
        end
        ST_SHIFT_B: begin
          r_self_hit <= r_self_hit | w_hit;
          if (r_idx == A_ONE) begin
            r_mem_addr  <= '0;
            r_mem_wen   <= ~(r_self_hit | w_hit);
            r_mem_wdata <= {r_nh_x, r_nh_y};
            r_state     <= ST_HEAD;
          end else begin
            r_mem_wen  <= 1'b0;
            r_idx      <= r_idx - A_ONE;
            r_mem_addr <= r_idx - A_TWO;
            r_state    <= ST_SHIFT_A;
          end
        end
        ST_HEAD: begin
          r_mem_wen <= 1'b0;
          r_busy    <= 1'b0;
          if (r_self_hit) begin
            r_game_over <= 1'b1;
            r_state     <= ST_OVER;
          end else begin
            r_head_x    <= r_nh_x;
            r_head_y    <= r_nh_y;
            r_length    <= r_top + 1'b1;
            r_last_dir  <= r_step_dir;
            r_step_done <= 1'b1;
            r_state     <= ST_WAIT;
          end
        end
        default: begin
          r_mem_wen <= 1'b0;
        end
      endcase
      // A grow arriving in the CALC cycle is kept for the following step
      if (r_state != ST_OVER && i_grow)
        r_grow_pend <= 1'b1;
    end
  end

  // Shift writes forward the RAM read data straight through
  assign o_mem_wdata = (r_state == ST_SHIFT_B) ? i_mem_rdata : r_mem_wdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wen   = r_mem_wen;
  assign o_head_x    = r_head_x;
  assign o_head_y    = r_head_y;
  assign o_length    = r_length;
  assign o_busy      = r_busy;
  assign o_step_done = r_step_done;
  assign o_game_over = r_game_over;

endmodule
